sequential_divider: RTL and testbench

- Multi-cycle restoring divider; the inverse-operation counterpart of the team's sequential shift-add multiplier.
- Same start/done operand handshake style, one quotient bit per clock.
- Standalone arithmetic unit, reusable by the same class-based bench structure.

---
 rtl/sequential_divider.sv | 139 +++++++++++++
 tb/tb_sequential_divider.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands with truncating division.
module sequential_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   prem_q;
  logic [WIDTH-1:0]   wdvd_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   rem_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;

  logic [WIDTH:0]     shift_d;
  logic               take_d;
  logic [WIDTH-1:0]   prem_d;
  logic [WIDTH-1:0]   wdvd_d;
  logic [WIDTH-1:0]   quo_fin_d;
  logic [WIDTH-1:0]   rem_fin_d;
  logic               last_d;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic               qneg_q;
  logic               rneg_q;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction
`endif

  // Partial remainder never exceeds the divisor, so the shifted value fits WIDTH+1 bits
  always_comb begin
    shift_d = {prem_q, wdvd_q[WIDTH-1]};
    take_d  = (shift_d >= {1'b0, dvs_q});
    prem_d  = take_d ? WIDTH'(shift_d - {1'b0, dvs_q}) : shift_d[WIDTH-1:0];
    wdvd_d  = {wdvd_q[WIDTH-2:0], take_d};
    last_d  = (cnt_q == CNT_W'(1));
`ifdef SEQ_DIVIDER_SIGNED_EN
    quo_fin_d = qneg_q ? -wdvd_d : wdvd_d;
    rem_fin_d = rneg_q ? -prem_d : prem_d;
`else
    quo_fin_d = wdvd_d;
    rem_fin_d = prem_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      wdvd_q  <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= CALC;
            cnt_q   <= CNT_W'(WIDTH);
            prem_q  <= '0;
            busy_q  <= 1'b1;
            dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            // Raw dividend is kept for a zero divisor so the remainder echoes it unchanged
            dvs_q   <= mag(divisor);
            wdvd_q  <= (divisor == '0) ? dividend : mag(dividend);
            qneg_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_q  <= dividend[WIDTH-1];
`else
            dvs_q   <= divisor;
            wdvd_q  <= dividend;
`endif
          end else begin
            state_q <= IDLE;
          end
        end
        CALC: begin
          if (dvs_q == '0) begin
            state_q <= DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            dbz_q   <= 1'b1;
            quo_q   <= '1;
            rem_q   <= wdvd_q;
          end else begin
            prem_q <= prem_d;
            wdvd_q <= wdvd_d;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (last_d) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              quo_q   <= quo_fin_d;
              rem_q   <= rem_fin_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed plan cases plus random operands
// compared against an arithmetic reference model.
module tb_sequential_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  sequential_divider #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the operand values
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa;
    int sb;
`endif
    if (b == 16'd0) begin
      q  = 16'hFFFF;
      r  = a;
      dz = 1'b1;
    end else begin
      dz = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = 16'(sa / sb);
      r  = 16'(sa % sb);
`else
      q  = a / b;
      r  = a % b;
`endif
    end
  endfunction

  // Called at a negedge; returns at the negedge where done is seen
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit noise,
                       input string tag);
    logic [15:0] eq;
    logic [15:0] er;
    logic        edz;
    int          cyc;
    int          busy_cyc;
    model(a, b, eq, er, edz);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    chk({tag, " dbz_cleared_on_accept"}, 32'(div_by_zero), 32'd0);
    cyc      = 0;
    busy_cyc = 0;
    while (!done && cyc < 64) begin
      if (busy) busy_cyc++;
      if (noise && cyc == 3) begin
        start    = 1'b1;
        dividend = 16'($urandom);
        divisor  = 16'($urandom_range(1, 255));
      end
      if (noise && cyc == 8) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, " latency"}, 32'(cyc), (b == 16'd0) ? 32'd1 : 32'd16);
    chk({tag, " busy_cycles"}, 32'(busy_cyc), (b == 16'd0) ? 32'd1 : 32'd16);
    chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, " quotient"}, 32'(quotient), 32'(eq));
    chk({tag, " remainder"}, 32'(remainder), 32'(er));
    chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
  endtask

  initial begin
    int done_seen;
    logic [15:0] ra;
    logic [15:0] rb;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'd100, 16'd7, 1'b0, "100/7");
    chk("100/7 q const", 32'(quotient), 32'd14);
    chk("100/7 r const", 32'(remainder), 32'd2);
    repeat (3) begin
      @(negedge clk);
      chk("idle done low", 32'(done), 32'd0);
      chk("idle busy low", 32'(busy), 32'd0);
      chk("idle q held", 32'(quotient), 32'd14);
      chk("idle r held", 32'(remainder), 32'd2);
    end

    do_op(16'hFFFF, 16'd1, 1'b0, "FFFF/1");
    chk("FFFF/1 q const", 32'(quotient), 32'hFFFF);
    do_op(16'd5, 16'd9, 1'b0, "b2b 5/9");
    chk("5/9 q const", 32'(quotient), 32'd0);
    chk("5/9 r const", 32'(remainder), 32'd5);
    @(negedge clk);
    chk("b2b single done", 32'(done), 32'd0);

    @(negedge clk);
    do_op(16'd1234, 16'd0, 1'b0, "1234/0");
    chk("1234/0 q const", 32'(quotient), 32'hFFFF);
    chk("1234/0 r const", 32'(remainder), 32'd1234);
    chk("1234/0 flag", 32'(div_by_zero), 32'd1);
    @(negedge clk);
    chk("dbz flag held", 32'(div_by_zero), 32'd1);
    do_op(16'd40, 16'd6, 1'b0, "after dbz 40/6");

    @(negedge clk);
    do_op(16'd1000, 16'd3, 1'b1, "noise 1000/3");
    chk("noise q const", 32'(quotient), 32'd333);
    chk("noise r const", 32'(remainder), 32'd1);
    @(negedge clk);
    chk("noise no extra done", 32'(done), 32'd0);
    chk("noise no restart", 32'(busy), 32'd0);

    // Abort mid-operation: reset in the 8th CALC cycle
    start    = 1'b1;
    dividend = 16'h1234;
    divisor  = 16'h0011;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort quotient", 32'(quotient), 32'd0);
    chk("abort remainder", 32'(remainder), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    chk("abort no done after release", 32'(done_seen), 32'd0);
    do_op(16'd50, 16'd5, 1'b0, "50/5");
    chk("50/5 q const", 32'(quotient), 32'd10);
    chk("50/5 r const", 32'(remainder), 32'd0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    @(negedge clk);
    do_op(16'hFFF9, 16'd2, 1'b0, "-7/2");
    chk("-7/2 q const", 32'(quotient), 32'hFFFD);
    chk("-7/2 r const", 32'(remainder), 32'hFFFF);
    do_op(16'd7, 16'hFFFE, 1'b0, "7/-2");
    chk("7/-2 q const", 32'(quotient), 32'hFFFD);
    chk("7/-2 r const", 32'(remainder), 32'd1);
    do_op(16'h8000, 16'hFFFF, 1'b0, "min/-1");
    chk("min/-1 q const", 32'(quotient), 32'h8000);
    chk("min/-1 r const", 32'(remainder), 32'd0);
`endif

    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 40)) : 16'($urandom);
      if (i % 3 == 0) @(negedge clk);
      do_op(ra, rb, 1'b0, "random");
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
